// File: rtl/bcd_count_monitor_if.sv
// Observation bus between a decimal up/down counter and its receive-side monitor.
// The master drives the sampled counter values; the slave (monitor) drives the status.
interface bcd_count_monitor_if #(
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 8
);
  logic              in_valid;
  logic [3:0]        number;
  logic              zero;
  logic              locked;
  logic              dir;
  logic              dir_chg;
  logic              wrap;
  logic [WRAP_W-1:0] wrap_cnt;
  logic              err;
  logic [1:0]        err_code;
  logic [ERR_W-1:0]  err_cnt;

  modport master (
    output in_valid, number, zero,
    input  locked, dir, dir_chg, wrap, wrap_cnt, err, err_code, err_cnt
  );

  modport slave (
    input  in_valid, number, zero,
    output locked, dir, dir_chg, wrap, wrap_cnt, err, err_code, err_cnt
  );
endinterface

// File: rtl/bcd_count_monitor.sv
// Receive-side checker for a decimal up/down counter: infers direction, flags
// range/zero/sequence violations and counts legal wrap-arounds. All outputs registered.
//   state | meaning
//   IDLE  | no reference value held; next in-range sample becomes prev
//   ACQ   | prev held, waiting for a +1/-1 step to infer direction
//   LOCK  | direction known, every sample checked against prev
module bcd_count_monitor #(
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  bcd_count_monitor_if.slave  mon
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACQ = 2'd1, LOCK = 2'd2} state_t;

  state_t            r_state;
  logic [3:0]        r_prev;
  logic              r_dir;
  logic              r_locked;
  logic              r_dir_chg;
  logic              r_wrap;
  logic              r_err;
  logic [1:0]        r_err_code;
  logic [WRAP_W-1:0] r_wrap_cnt;
  logic [ERR_W-1:0]  r_err_cnt;

  logic       w_range;
  logic       w_zero_err;
  logic [3:0] w_inc;
  logic [3:0] w_dec;
  logic [3:0] w_exp;
  logic [3:0] w_opp;
  logic       w_fwd;
  logic       w_back;
  logic       w_wrap_pair;
  logic       w_wrap_ev;
  logic       w_seq_err;
  logic [1:0] w_code;

  assign w_range     = mon.number > 4'd9;
  assign w_zero_err  = mon.zero != (mon.number == 4'd0);
  assign w_inc       = (r_prev == 4'd9) ? 4'd0 : r_prev + 4'd1;
  assign w_dec       = (r_prev == 4'd0) ? 4'd9 : r_prev - 4'd1;
  assign w_exp       = r_dir ? w_inc : w_dec;
  assign w_opp       = r_dir ? w_dec : w_inc;
  assign w_fwd       = mon.number == w_exp;
  assign w_back      = mon.number == w_opp;
  assign w_wrap_pair = ((r_prev == 4'd9) && (mon.number == 4'd0)) ||
                       ((r_prev == 4'd0) && (mon.number == 4'd9));
  // A reversal that crosses 9/0 is a wrap in the new direction.
  assign w_wrap_ev   = mon.in_valid && (r_state == LOCK) && !w_range &&
                       (w_fwd || w_back) && w_wrap_pair;

  always_comb begin
    w_seq_err = 1'b0;
    case (r_state)
      ACQ:     w_seq_err = (mon.number != w_inc) && (mon.number != w_dec);
      LOCK:    w_seq_err = !w_fwd && !w_back;
      default: w_seq_err = 1'b0;
    endcase
  end

  always_comb begin
    w_code = 2'd0;
    if (w_range)         w_code = 2'd1;
    else if (w_zero_err) w_code = 2'd2;
    else if (w_seq_err)  w_code = 2'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_prev     <= 4'd0;
      r_dir      <= 1'b0;
      r_locked   <= 1'b0;
      r_dir_chg  <= 1'b0;
      r_wrap     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
      r_wrap_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_dir_chg  <= 1'b0;
      r_wrap     <= w_wrap_ev;
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
      if (w_wrap_ev && (r_wrap_cnt != '1)) r_wrap_cnt <= r_wrap_cnt + 1'b1;
      if (mon.in_valid) begin
        r_err      <= w_code != 2'd0;
        r_err_code <= w_code;
        if ((w_code != 2'd0) && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
        if (w_range) begin
          r_state  <= IDLE;
          r_locked <= 1'b0;
        end else begin
          r_prev <= mon.number;
          case (r_state)
            IDLE: r_state <= ACQ;
            ACQ: begin
              if (mon.number == w_inc) begin
                r_dir    <= 1'b1;
                r_locked <= 1'b1;
                r_state  <= LOCK;
              end else if (mon.number == w_dec) begin
                r_dir    <= 1'b0;
                r_locked <= 1'b1;
                r_state  <= LOCK;
              end
            end
            LOCK: begin
              if (!w_fwd && w_back) begin
                r_dir     <= ~r_dir;
                r_dir_chg <= 1'b1;
              end else if (!w_fwd) begin
                r_locked <= 1'b0;
                r_state  <= ACQ;
              end
            end
            default: r_state <= IDLE;
          endcase
        end
      end
    end
  end

  assign mon.locked   = r_locked;
  assign mon.dir      = r_dir;
  assign mon.dir_chg  = r_dir_chg;
  assign mon.wrap     = r_wrap;
  assign mon.wrap_cnt = r_wrap_cnt;
  assign mon.err      = r_err;
  assign mon.err_code = r_err_code;
  assign mon.err_cnt  = r_err_cnt;
endmodule

// File: tb/tb_bcd_count_monitor.sv
// Bench for bcd_count_monitor: directed vector table, hand-written corner
// sequences, and randomized stimulus against a modular-arithmetic reference model.
module tb_bcd_count_monitor;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_mis;

  bcd_count_monitor_if #(.WRAP_W(8), .ERR_W(8)) mon();

  bcd_count_monitor #(.WRAP_W(8), .ERR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .mon (mon)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [3:0] n;
    logic       z;
    logic       l;
    logic       d;
    logic       dc;
    logic       w;
    logic       e;
    logic [1:0] c;
    logic [7:0] wc;
    logic [7:0] ec;
  } vec_t;

  vec_t tbl [45];

  function automatic vec_t mk(logic v, logic [3:0] n, logic z, logic l, logic d,
                              logic dc, logic w, logic e, logic [1:0] c,
                              logic [7:0] wc, logic [7:0] ec);
    vec_t t;
    t.v = v; t.n = n; t.z = z; t.l = l; t.d = d; t.dc = dc;
    t.w = w; t.e = e; t.c = c; t.wc = wc; t.ec = ec;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic l, input logic d, input logic dc,
                           input logic w, input logic e, input logic [1:0] c,
                           input logic [7:0] wc, input logic [7:0] ec);
    chk({tag, ".locked"},   32'(mon.locked),   32'(l));
    chk({tag, ".dir"},      32'(mon.dir),      32'(d));
    chk({tag, ".dir_chg"},  32'(mon.dir_chg),  32'(dc));
    chk({tag, ".wrap"},     32'(mon.wrap),     32'(w));
    chk({tag, ".err"},      32'(mon.err),      32'(e));
    chk({tag, ".err_code"}, 32'(mon.err_code), 32'(c));
    chk({tag, ".wrap_cnt"}, 32'(mon.wrap_cnt), 32'(wc));
    chk({tag, ".err_cnt"},  32'(mon.err_cnt),  32'(ec));
  endtask

  task automatic drive(input logic v, input logic [3:0] n, input logic z);
    @(negedge clk);
    mon.in_valid = v;
    mon.number   = n;
    mon.zero     = z;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    mon.in_valid = 1'b0;
    mon.number   = 4'd0;
    mon.zero     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference model: mode 0 = no reference, 1 = acquiring, 2 = locked
  int m_mode, m_prev, m_dir, m_locked, m_wc, m_ec;
  int e_dc, e_w, e_code;

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_dir = 0; m_locked = 0; m_wc = 0; m_ec = 0;
    e_dc = 0; e_w = 0; e_code = 0;
  endtask

  task automatic model_step(input int v, input int n, input int z);
    int up, dn, fwd, back, seq, zerr, diff;
    e_dc = 0; e_w = 0; e_code = 0;
    if (v == 0) return;
    up   = (m_prev + 1) % 10;
    dn   = (m_prev + 9) % 10;
    zerr = (z != ((n == 0) ? 1 : 0)) ? 1 : 0;
    seq  = 0;
    if (n > 9) begin
      m_mode = 0;
      m_locked = 0;
    end else begin
      if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (n == up || n == dn) begin
          m_dir = (n == up) ? 1 : 0;
          m_locked = 1;
          m_mode = 2;
        end else seq = 1;
      end else begin
        fwd  = m_dir ? up : dn;
        back = m_dir ? dn : up;
        diff = (n > m_prev) ? n - m_prev : m_prev - n;
        if (n == fwd || n == back) begin
          if (diff == 9) e_w = 1;
          if (n != fwd) begin
            m_dir = 1 - m_dir;
            e_dc = 1;
          end
        end else begin
          seq = 1;
          m_locked = 0;
          m_mode = 1;
        end
      end
      m_prev = n;
    end
    e_code = (n > 9) ? 1 : (zerr != 0) ? 2 : (seq != 0) ? 3 : 0;
    if (e_code != 0 && m_ec < 255) m_ec++;
    if (e_w != 0 && m_wc < 255) m_wc++;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst = 1'b1;
    mon.in_valid = 1'b0;
    mon.number   = 4'd0;
    mon.zero     = 1'b0;

    tbl[0]  = mk(1, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0,  1, 1, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 2, 0,  1, 1, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 3, 0,  1, 1, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 4, 0,  1, 1, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 5, 0,  1, 1, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1, 6, 0,  1, 1, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 7, 0,  1, 1, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(1, 8, 0,  1, 1, 0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(1, 9, 0,  1, 1, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(1, 0, 1,  1, 1, 0, 1, 0, 0, 1, 0);
    tbl[11] = mk(1, 1, 0,  1, 1, 0, 0, 0, 0, 1, 0);
    tbl[12] = mk(1, 2, 0,  1, 1, 0, 0, 0, 0, 1, 0);
    tbl[13] = mk(1, 3, 0,  1, 1, 0, 0, 0, 0, 1, 0);
    tbl[14] = mk(1, 4, 0,  1, 1, 0, 0, 0, 0, 1, 0);
    tbl[15] = mk(1, 5, 0,  1, 1, 0, 0, 0, 0, 1, 0);
    tbl[16] = mk(1, 4, 0,  1, 0, 1, 0, 0, 0, 1, 0);
    tbl[17] = mk(1, 3, 0,  1, 0, 0, 0, 0, 0, 1, 0);
    tbl[18] = mk(1, 2, 0,  1, 0, 0, 0, 0, 0, 1, 0);
    tbl[19] = mk(1, 1, 0,  1, 0, 0, 0, 0, 0, 1, 0);
    tbl[20] = mk(1, 0, 1,  1, 0, 0, 0, 0, 0, 1, 0);
    tbl[21] = mk(1, 9, 0,  1, 0, 0, 1, 0, 0, 2, 0);
    tbl[22] = mk(1, 0, 1,  1, 1, 1, 1, 0, 0, 3, 0);
    tbl[23] = mk(1, 1, 0,  1, 1, 0, 0, 0, 0, 3, 0);
    tbl[24] = mk(1, 2, 0,  1, 1, 0, 0, 0, 0, 3, 0);
    tbl[25] = mk(1, 3, 0,  1, 1, 0, 0, 0, 0, 3, 0);
    tbl[26] = mk(1, 7, 0,  0, 1, 0, 0, 1, 3, 3, 1);
    tbl[27] = mk(1, 8, 0,  1, 1, 0, 0, 0, 0, 3, 1);
    tbl[28] = mk(1, 7, 0,  1, 0, 1, 0, 0, 0, 3, 1);
    tbl[29] = mk(1, 6, 0,  1, 0, 0, 0, 0, 0, 3, 1);
    tbl[30] = mk(1, 5, 0,  1, 0, 0, 0, 0, 0, 3, 1);
    tbl[31] = mk(1, 4, 1,  1, 0, 0, 0, 1, 2, 3, 2);
    tbl[32] = mk(1, 3, 0,  1, 0, 0, 0, 0, 0, 3, 2);
    tbl[33] = mk(1, 12, 0, 0, 0, 0, 0, 1, 1, 3, 3);
    tbl[34] = mk(1, 5, 0,  0, 0, 0, 0, 0, 0, 3, 3);
    tbl[35] = mk(1, 5, 0,  0, 0, 0, 0, 1, 3, 3, 4);
    tbl[36] = mk(1, 4, 0,  1, 0, 0, 0, 0, 0, 3, 4);
    tbl[37] = mk(1, 4, 0,  0, 0, 0, 0, 1, 3, 3, 5);
    tbl[38] = mk(0, 9, 1,  0, 0, 0, 0, 0, 0, 3, 5);
    tbl[39] = mk(1, 5, 0,  1, 1, 0, 0, 0, 0, 3, 5);
    tbl[40] = mk(0, 15, 1, 1, 1, 0, 0, 0, 0, 3, 5);
    tbl[41] = mk(0, 2, 1,  1, 1, 0, 0, 0, 0, 3, 5);
    tbl[42] = mk(0, 9, 0,  1, 1, 0, 0, 0, 0, 3, 5);
    tbl[43] = mk(1, 6, 0,  1, 1, 0, 0, 0, 0, 3, 5);
    tbl[44] = mk(1, 7, 1,  1, 1, 0, 0, 1, 2, 3, 6);

    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 45; i++) begin
      drive(tbl[i].v, tbl[i].n, tbl[i].z);
      check_all($sformatf("vec%0d", i), tbl[i].l, tbl[i].d, tbl[i].dc, tbl[i].w,
                tbl[i].e, tbl[i].c, tbl[i].wc, tbl[i].ec);
    end

    // Asynchronous reset mid-stream, then a zero-flag error on the first IDLE sample
    drive(1, 8, 0);
    rst = 1'b1;
    #2;
    check_all("midrst", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 3, 1);
    check_all("idle_zero", 0, 0, 0, 0, 1, 2, 0, 1);
    drive(1, 4, 0);
    check_all("relock", 1, 1, 0, 0, 0, 0, 0, 1);

    // Wrap counter saturation: 300 up-wraps
    do_reset();
    drive(1, 0, 1);
    for (int k = 1; k <= 3000; k++) begin
      drive(1, 4'(k % 10), (k % 10) == 0);
    end
    check_all("wrap_sat", 1, 1, 0, 1, 0, 0, 8'd255, 0);

    // Error counter saturation: 300 out-of-range samples
    do_reset();
    for (int k = 0; k < 300; k++) drive(1, 4'd15, 1'b0);
    check_all("err_sat", 0, 0, 0, 0, 1, 1, 0, 8'd255);

    // Randomized stream against the reference model
    do_reset();
    model_reset();
    for (int k = 0; k < 3000; k++) begin
      int r, v, n, z;
      v = ($urandom_range(0, 9) != 0) ? 1 : 0;
      r = $urandom_range(0, 99);
      if (r < 60)      n = m_dir ? (m_prev + 1) % 10 : (m_prev + 9) % 10;
      else if (r < 75) n = m_dir ? (m_prev + 9) % 10 : (m_prev + 1) % 10;
      else if (r < 82) n = m_prev;
      else if (r < 94) n = $urandom_range(0, 9);
      else             n = $urandom_range(10, 15);
      z = (n == 0) ? 1 : 0;
      if ($urandom_range(0, 19) == 0) z = 1 - z;
      drive(v[0], 4'(n), z[0]);
      model_step(v, n, z);
      check_all($sformatf("rnd%0d", k), m_locked[0], m_dir[0], e_dc[0], e_w[0],
                e_code != 0, 2'(e_code), 8'(m_wc), 8'(m_ec));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/bcd_count_monitor.md
Name: bcd_count_monitor

Overview:
- Receive-side checker for the decimal up/down counter interface, which presents a 4-bit `number` and a `zero` flag every clock.
- Infers the count direction and tracks the stream. Flags range, zero-flag and sequence violations. Counts legal wrap-arounds (9->0 up, 0->9 down).
- Sits beside the counter as a bus monitor and self-check. All outputs are registered.

Parameters:
- WRAP_W, 8, width of the saturating wrap counter.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  sample qualifier; 1 = number/zero valid this cycle.
- number  input  4  observed count value, legal range 0..9.
- zero  input  1  observed zero flag; must equal (number==0).
- locked  output  1  direction acquired and stream in sequence.
- dir  output  1  inferred direction: 1 = up, 0 = down; meaningful only when locked=1.
- dir_chg  output  1  one-cycle pulse when a legal direction reversal is seen.
- wrap  output  1  one-cycle pulse on a legal wrap (9->0 while up, 0->9 while down).
- wrap_cnt  output  WRAP_W  saturating count of wrap pulses.
- err  output  1  one-cycle pulse on any violation.
- err_code  output  2  cause of err: 0 none, 1 RANGE, 2 ZERO, 3 SEQ. Equals 0 whenever err=0.
- err_cnt  output  ERR_W  saturating count of err pulses.

Behaviour:
Reset and latency
- Reset is asynchronous and active-high. While rst=1: state=IDLE, prev=0, and every output is 0.
- Latency: a sample accepted at edge N produces its flags after edge N; there is no combinational path from inputs to outputs.
- in_valid=0: state, prev, dir and counters hold; all pulses (dir_chg, wrap, err) are 0 and err_code=0.

Helper functions
- inc(p) = (p==9) ? 0 : p+1.
- dec(p) = (p==0) ? 9 : p-1.

Per-sample checks (valid sample only)
- RANGE: number > 9.
- ZERO: zero != (number==0).
- Error priority for err_code is RANGE > ZERO > SEQ. Only one err pulse is issued per sample.

State machine
IDLE:
- Sample without RANGE: prev <= number; go to ACQ. A ZERO error is still reported.
- Sample with RANGE: report RANGE; stay in IDLE.

ACQ:
- RANGE: report RANGE; go to IDLE.
- number == inc(prev): dir <= 1; locked <= 1; go to LOCK.
- Else number == dec(prev): dir <= 0; locked <= 1; go to LOCK.
- Otherwise: report SEQ (unless ZERO has priority); stay in ACQ.
- In every non-RANGE case, prev <= number.
- No wrap pulse is generated in ACQ.

LOCK:
- Define exp = dir ? inc(prev) : dec(prev), and opp = dir ? dec(prev) : inc(prev).
- number == exp: in sequence; prev <= number. Pulse wrap if (dir=1 and prev=9 and number=0) or (dir=0 and prev=0 and number=9).
- number == opp: dir <= ~dir; pulse dir_chg; prev <= number; no error.
  - A wrap in the new direction also pulses wrap (e.g. down at 0 reversing up is not a wrap, but up at 0 reversing to 9 is).
- Neither: report SEQ; locked <= 0; prev <= number; go to ACQ.
- RANGE: report RANGE; locked <= 0; go to IDLE.
- A ZERO error alone does not drop lock; sequence tracking continues on `number`.

Counters and boundaries
- wrap_cnt increments on each wrap pulse.
- err_cnt increments on each err pulse.
- Both counters saturate at all-ones and never wrap.
- The boundary cases are prev=9 with dir=1 and prev=0 with dir=0, with the wrap rules as above.
- A repeated value (number==prev) is a SEQ error in both ACQ and LOCK.
- Reset asserted mid-stream clears everything immediately. The first sample after deassertion is treated as IDLE.

Test Plan:
1. Reset, then valid stream 0,1,...,9,0,1 with correct zero -> locked=1 after 2nd sample, dir=1; wrap pulses once at the 9->0 sample; wrap_cnt=1; err never asserts.
2. Locked up at 5, then stream 4,3,2,1,0,9 -> dir_chg pulse on sample 4, dir=0; wrap pulse on 0->9; err=0 throughout.
3. Locked up, sample 3 then 7 -> err=1 with err_code=3 one cycle after the 7; locked=0. Next sample 8 -> relocked, dir=1.
4. Locked, number=4 with zero=1 -> err_code=2; locked stays 1; sequence continues. Then number=12 -> err_code=1; state returns to IDLE; err_cnt=2.
5. in_valid=0 for 3 cycles in the middle of the stream -> outputs and counters hold; the sequence resumes from held prev without error. Asserting rst mid-stream -> all outputs 0 asynchronously.
6. Force 300 wraps with WRAP_W=8 -> wrap_cnt saturates at 255.
